// File: rtl/scope_acq_ctrl.sv
// Scope acquisition controller: decimates the ADC stream, detects a level-crossing trigger
// and captures one frame into the write bank of a ping-pong buffer swapped on frame_sync.
module scope_acq_ctrl #(
    parameter int NSAMP        = 160,
    parameter int DECIM        = 4,
    parameter int AUTO_TIMEOUT = 1000
) (
    input  logic        clk,
    input  logic        lock,
    input  logic [13:0] adc,
    input  logic [1:0]  mode,
    input  logic        arm,
    input  logic [7:0]  trig_level,
    input  logic        trig_slope,
    input  logic        frame_sync,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        wr_bank,
    output logic        rd_bank,
    output logic [1:0]  state,
    output logic        trig_forced
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam int TW = $clog2(AUTO_TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ARMED   = 2'd1;
    localparam logic [1:0] ST_CAPTURE = 2'd2;
    localparam logic [1:0] ST_HOLD    = 2'd3;

    localparam logic [1:0] MODE_AUTO   = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b10;

    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [1:0]    state_q, state_d;
    logic [7:0]    prev_q, prev_d;
    logic          prev_v_q, prev_v_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic          wr_en_q, wr_en_d;
    logic [7:0]    wr_addr_q, wr_addr_d;
    logic [7:0]    wr_data_q, wr_data_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          trig_forced_q, trig_forced_d;

    logic       tick;
    logic [7:0] s;
    logic       rise_hit;
    logic       fall_hit;
    logic       trig_hit;
    logic       timeout_hit;
    logic [7:0] next_addr;
    logic       unused_adc_lsbs;

    assign tick            = (dcnt_q == DW'(DECIM - 1));
    assign s               = adc[13:6];
    assign unused_adc_lsbs = ^adc[5:0];

    assign rise_hit    = (prev_q < trig_level) && (s >= trig_level);
    assign fall_hit    = (prev_q > trig_level) && (s <= trig_level);
    assign trig_hit    = tick && prev_v_q && (trig_slope ? rise_hit : fall_hit);
    // to_cnt saturates, so a long wait in normal mode followed by a switch to auto fires at once
    assign timeout_hit = tick && (mode == MODE_AUTO) && (to_cnt_q >= TW'(AUTO_TIMEOUT - 1));
    assign next_addr   = wr_addr_q + 8'd1;

    always_comb begin
        dcnt_d        = tick ? '0 : dcnt_q + DW'(1);
        state_d       = state_q;
        prev_d        = tick ? s : prev_q;
        prev_v_d      = prev_v_q;
        to_cnt_d      = to_cnt_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        trig_forced_d = trig_forced_q;

        case (state_q)
            ST_IDLE: begin
                if ((mode != MODE_SINGLE) || arm) begin
                    state_d  = ST_ARMED;
                    prev_v_d = 1'b0;
                end
            end
            ST_ARMED: begin
                if (tick) begin
                    prev_v_d = 1'b1;
                    if (to_cnt_q != TW'(AUTO_TIMEOUT)) begin
                        to_cnt_d = to_cnt_q + TW'(1);
                    end
                    if (trig_hit || timeout_hit) begin
                        wr_en_d       = 1'b1;
                        wr_addr_d     = 8'd0;
                        wr_data_d     = s;
                        trig_forced_d = ~trig_hit;
                        to_cnt_d      = '0;
                        state_d       = (NSAMP == 1) ? ST_HOLD : ST_CAPTURE;
                    end
                end
            end
            ST_CAPTURE: begin
                if (tick) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = next_addr;
                    wr_data_d = s;
                    if (next_addr == 8'(NSAMP - 1)) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            default: begin
                if (frame_sync) begin
                    wr_bank_d = ~wr_bank_q;
                    rd_bank_d = ~rd_bank_q;
                    if (mode == MODE_SINGLE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d  = ST_ARMED;
                        prev_v_d = 1'b0;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!lock) begin
            dcnt_q        <= '0;
            state_q       <= ST_IDLE;
            prev_q        <= 8'd0;
            prev_v_q      <= 1'b0;
            to_cnt_q      <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= 8'd0;
            wr_data_q     <= 8'd0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b1;
            trig_forced_q <= 1'b0;
        end else begin
            dcnt_q        <= dcnt_d;
            state_q       <= state_d;
            prev_q        <= prev_d;
            prev_v_q      <= prev_v_d;
            to_cnt_q      <= to_cnt_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            trig_forced_q <= trig_forced_d;
        end
    end

    assign wr_en       = wr_en_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;
    assign wr_bank     = wr_bank_q;
    assign rd_bank     = rd_bank_q;
    assign state       = state_q;
    assign trig_forced = trig_forced_q;

endmodule

// File: tb/tb_scope_acq_ctrl.sv
// Bench for scope_acq_ctrl: a directed vector table, scenario sequences and random traffic,
// all compared every cycle against a behavioural model of the acquisition rules.
module tb_scope_acq_ctrl;

    localparam int NSAMP   = 160;
    localparam int DECIM   = 4;
    localparam int AUTO_TO = 10;

    logic        clk = 1'b0;
    logic        lock;
    logic [13:0] adc;
    logic [1:0]  mode;
    logic        arm;
    logic [7:0]  trig_level;
    logic        trig_slope;
    logic        frame_sync;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        wr_bank;
    logic        rd_bank;
    logic [1:0]  state;
    logic        trig_forced;

    always #5 clk = ~clk;

    scope_acq_ctrl #(.NSAMP(NSAMP), .DECIM(DECIM), .AUTO_TIMEOUT(AUTO_TO)) dut (
        .clk(clk), .lock(lock), .adc(adc), .mode(mode), .arm(arm),
        .trig_level(trig_level), .trig_slope(trig_slope), .frame_sync(frame_sync),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .state(state), .trig_forced(trig_forced)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model: cycles since reset, phase 0..3 (IDLE/ARMED/CAPTURE/HOLD), ticks spent armed
    int m_cyc, m_state, m_prev, m_to, m_idx, m_addr, m_data;
    bit m_prev_v, m_bank, m_forced, m_wr_en, m_rst;

    int cyc_now = 0;
    int rst_cyc, wr_count, first_wr_cyc, last_wr_cyc, first_wr_data, first_forced, last_wr_bank;
    int ramp_base = 8'h70;
    int ramp_step = 8;

    typedef struct {
        bit       lock;
        bit [7:0] s;
        bit [1:0] mode;
        bit       arm;
        bit       fs;
        bit [1:0] exp_state;
        bit       exp_wr_en;
        bit       exp_bank;
    } vec_t;

    vec_t vecs[12];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic model_step(input bit l, input int s, input int md, input bit a, input bit fs);
        bit tick;
        bit hit;
        int lvl;
        lvl     = int'(trig_level);
        m_wr_en = 0;
        m_rst   = 0;
        if (!l) begin
            m_cyc = 0; m_state = 0; m_addr = 0; m_data = 0; m_bank = 0; m_forced = 0;
            m_prev = 0; m_prev_v = 0; m_to = 0; m_rst = 1;
            return;
        end
        tick = ((m_cyc % DECIM) == DECIM - 1);
        m_cyc++;
        case (m_state)
            0: if (md != 2 || a) begin m_state = 1; m_prev_v = 0; end
            1: if (tick) begin
                m_to++;
                hit = m_prev_v && (trig_slope ? (m_prev < lvl && s >= lvl) : (m_prev > lvl && s <= lvl));
                m_prev_v = 1;
                if (hit || (md == 0 && m_to >= AUTO_TO)) begin
                    m_wr_en = 1; m_addr = 0; m_data = s;
                    m_forced = !hit; m_to = 0; m_idx = 1; m_state = 2;
                end
            end
            2: if (tick) begin
                m_wr_en = 1; m_addr = m_idx; m_data = s;
                if (m_idx == NSAMP - 1) m_state = 3;
                m_idx++;
            end
            default: if (fs) begin
                m_bank = !m_bank;
                if (md == 2) m_state = 0;
                else begin m_state = 1; m_prev_v = 0; end
            end
        endcase
        if (tick) m_prev = s;
    endtask

    function automatic bit [7:0] ramp_s();
        return 8'((ramp_base + ramp_step * (m_cyc / DECIM)) & 255);
    endfunction

    task automatic applyStimulus(input bit l, input bit [7:0] s, input bit [1:0] md, input bit a, input bit fs);
        logic [21:0] exp_v, act_v;
        lock = l; adc = {s, 6'($urandom)}; mode = md; arm = a; frame_sync = fs;
        model_step(l, int'(s), int'(md), a, fs);
        @(posedge clk);
        #1;
        cyc_now++;
        exp_v = {m_wr_en, 8'(m_addr), 8'(m_data), m_bank, !m_bank, 2'(m_state), m_forced};
        act_v = {wr_en, wr_addr, wr_data, wr_bank, rd_bank, state, trig_forced};
        if (!m_wr_en && !m_rst) begin
            exp_v[20:5] = '0;
            act_v[20:5] = '0;
        end
        checkOutput("model", 32'(act_v), 32'(exp_v));
        if (wr_en === 1'b1) begin
            wr_count++;
            if (wr_addr == 8'd0) begin
                first_wr_cyc = cyc_now; first_wr_data = int'(wr_data); first_forced = int'(trig_forced);
            end
            last_wr_cyc  = cyc_now;
            last_wr_bank = int'(wr_bank);
        end
    endtask

    task automatic do_reset(input bit [1:0] md);
        applyStimulus(1'b0, 8'h00, md, 1'b0, 1'b0);
        wr_count = 0; first_wr_cyc = -1; last_wr_cyc = -1; first_wr_data = -1; first_forced = -1;
        rst_cyc = cyc_now;
    endtask

    task automatic run_until(input int target, input int max_cycles, input bit [1:0] md, input int fs_every);
        for (int i = 0; i < max_cycles; i++) begin
            if (state === 2'(target)) break;
            applyStimulus(1'b1, ramp_s(), md, 1'b0, (fs_every > 0) && (cyc_now % fs_every == 0));
        end
        checkOutput("reach_state", 32'(state), 32'(target));
    endtask

    task automatic run_group(input bit [7:0] s, input bit [1:0] md);
        for (int i = 0; i < DECIM; i++) applyStimulus(1'b1, s, md, 1'b0, 1'b0);
    endtask

    initial begin
        lock = 0; adc = '0; mode = 2'b01; arm = 0; frame_sync = 0;
        trig_level = 8'h80; trig_slope = 1'b1;

        // Directed table, single mode from reset, level 0x80 rising
        vecs[0]  = '{0, 8'h00, 2, 0, 0, 0, 0, 0};
        vecs[1]  = '{1, 8'h10, 2, 0, 0, 0, 0, 0};
        vecs[2]  = '{1, 8'h10, 2, 0, 1, 0, 0, 0};
        vecs[3]  = '{1, 8'h10, 2, 1, 0, 1, 0, 0};
        vecs[4]  = '{1, 8'h10, 2, 0, 0, 1, 0, 0};
        vecs[5]  = '{1, 8'h90, 2, 0, 0, 1, 0, 0};
        vecs[6]  = '{1, 8'h90, 2, 0, 0, 1, 0, 0};
        vecs[7]  = '{1, 8'h90, 2, 1, 0, 1, 0, 0};
        vecs[8]  = '{1, 8'h90, 2, 0, 0, 2, 1, 0};
        vecs[9]  = '{1, 8'h90, 2, 0, 1, 2, 0, 0};
        vecs[10] = '{0, 8'h90, 2, 0, 0, 0, 0, 0};
        vecs[11] = '{1, 8'h90, 1, 0, 0, 1, 0, 0};
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].lock, vecs[i].s, vecs[i].mode, vecs[i].arm, vecs[i].fs);
            checkOutput($sformatf("table[%0d]", i), 32'({state, wr_en, wr_bank}),
                        32'({vecs[i].exp_state, vecs[i].exp_wr_en, vecs[i].exp_bank}));
        end

        // Rising ramp in normal mode, frame_sync pulses during capture must be ignored
        $display("[TB] rising trigger / ping-pong");
        ramp_base = 8'h70; ramp_step = 8;
        do_reset(2'b01);
        run_until(3, 1000, 2'b01, 37);
        checkOutput("rise_addr0_data", 32'(first_wr_data), 32'h80);
        checkOutput("rise_latency", 32'(first_wr_cyc - rst_cyc), 32'd12);
        checkOutput("rise_frame_len", 32'(last_wr_cyc - first_wr_cyc), 32'(159 * DECIM));
        checkOutput("rise_write_count", 32'(wr_count), 32'(NSAMP));
        checkOutput("rise_forced", 32'(first_forced), 32'd0);
        checkOutput("bank_after_capture", 32'({wr_bank, rd_bank}), 32'b01);
        applyStimulus(1'b1, ramp_s(), 2'b01, 1'b0, 1'b1);
        checkOutput("swap_banks", 32'({wr_bank, rd_bank}), 32'b10);
        checkOutput("swap_state", 32'(state), 32'd1);
        checkOutput("swap_no_write", 32'(wr_en), 32'd0);
        wr_count = 0;
        run_until(3, 3000, 2'b01, 0);
        checkOutput("frame2_bank", 32'(last_wr_bank), 32'd1);
        checkOutput("frame2_count", 32'(wr_count), 32'(NSAMP));

        // Falling edge at 0x40: 0x40 then 0x3F must not trigger, 0x50 then 0x40 must
        $display("[TB] falling trigger");
        trig_level = 8'h40; trig_slope = 1'b0;
        do_reset(2'b01);
        run_group(8'h40, 2'b01);
        run_group(8'h3F, 2'b01);
        checkOutput("fall_no_trig_eq", 32'({state, wr_en}), 32'({2'd1, 1'b0}));
        run_group(8'h50, 2'b01);
        checkOutput("fall_no_trig_up", 32'({state, wr_en}), 32'({2'd1, 1'b0}));
        run_group(8'h40, 2'b01);
        checkOutput("fall_trig", 32'({state, wr_en, wr_addr, wr_data}), 32'({2'd2, 1'b1, 8'd0, 8'h40}));

        // Auto mode with flat input: forced on 10th tick in ARMED
        $display("[TB] auto timeout");
        trig_level = 8'h80; trig_slope = 1'b1;
        ramp_base = 8'h20; ramp_step = 0;
        do_reset(2'b00);
        run_until(2, 200, 2'b00, 0);
        checkOutput("auto_latency", 32'(first_wr_cyc - rst_cyc), 32'(AUTO_TO * DECIM));
        checkOutput("auto_forced", 32'(first_forced), 32'd1);
        checkOutput("auto_data", 32'(first_wr_data), 32'h20);
        run_until(3, 1000, 2'b00, 0);
        checkOutput("auto_count", 32'(wr_count), 32'(NSAMP));
        checkOutput("auto_forced_hold", 32'(trig_forced), 32'd1);

        // Single mode: idle until arm, arm ignored in capture, back to IDLE after swap
        $display("[TB] single mode");
        ramp_base = 8'h70; ramp_step = 8;
        do_reset(2'b10);
        for (int i = 0; i < 20; i++) applyStimulus(1'b1, ramp_s(), 2'b10, 1'b0, 1'b0);
        checkOutput("single_idle", 32'({state, 8'(wr_count)}), 32'({2'd0, 8'd0}));
        applyStimulus(1'b1, ramp_s(), 2'b10, 1'b1, 1'b0);
        checkOutput("single_armed", 32'(state), 32'd1);
        run_until(2, 400, 2'b10, 0);
        applyStimulus(1'b1, ramp_s(), 2'b10, 1'b1, 1'b0);
        run_until(3, 1000, 2'b10, 0);
        applyStimulus(1'b1, ramp_s(), 2'b10, 1'b0, 1'b1);
        checkOutput("single_return", 32'({state, wr_bank, rd_bank}), 32'({2'd0, 1'b1, 1'b0}));
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, ramp_s(), 2'b10, 1'b0, 1'b0);
        checkOutput("single_stays_idle", 32'(state), 32'd0);

        // Reset while capturing at addr 75, then a clean restart from addr 0
        $display("[TB] reset mid-capture");
        do_reset(2'b01);
        for (int i = 0; i < 1000; i++) begin
            if (wr_en === 1'b1 && wr_addr == 8'd75) break;
            applyStimulus(1'b1, ramp_s(), 2'b01, 1'b0, 1'b0);
        end
        checkOutput("reached_addr75", 32'(wr_addr), 32'd75);
        applyStimulus(1'b0, ramp_s(), 2'b01, 1'b0, 1'b0);
        checkOutput("reset_outputs", 32'({state, wr_en, wr_addr, wr_data, wr_bank, rd_bank, trig_forced}),
                    32'({2'd0, 1'b0, 8'd0, 8'd0, 1'b0, 1'b1, 1'b0}));
        wr_count = 0;
        for (int i = 0; i < 400; i++) begin
            if (wr_count > 0) break;
            applyStimulus(1'b1, ramp_s(), 2'b01, 1'b0, 1'b0);
        end
        checkOutput("restart_addr0", 32'({wr_en, wr_addr}), 32'({1'b1, 8'd0}));

        // Random traffic around the threshold with occasional reset
        $display("[TB] random traffic");
        begin
            bit [1:0] md;
            int lvl;
            md = 2'b00;
            for (int i = 0; i < 8000; i++) begin
                if ($urandom_range(0, 199) == 0) md = 2'($urandom);
                if ($urandom_range(0, 299) == 0) trig_slope = 1'($urandom);
                if ($urandom_range(0, 499) == 0) trig_level = 8'($urandom);
                lvl = int'(trig_level) + int'($urandom_range(0, 16)) - 8;
                applyStimulus($urandom_range(0, 999) != 0,
                              ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'(lvl),
                              md, $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
